bram_win_ctrl: RTL
==================

// Module: bram_win_ctrl
// PURPOSE
//  Ping-pong window controller between the median-filter output and the sample BRAM write port.
//  Splits the BRAM into two banks of DEPTH/2 entries. Fills one bank while the PicoBlaze reads the other.
//  Raises the CPU interrupt once per full bank and tracks ownership through an ack/done handshake.
//  Drops and counts samples when both banks are CPU-owned. Replaces the free-running write FSM.
// PARAMETERS
//  DATA_W   16  sample / BRAM data width
//  ADDR_W   4   BRAM address width; DEPTH=2**ADDR_W, bank size BANK=DEPTH/2; MSB = bank select
//  OVF_W    8   width of saturating drop counter
// PORTS
//  clk_i        in   1        system clock; all logic on rising edge
//  rst_i        in   1        reset, asynchronous, active-high
//  sample_i     in   DATA_W   median value
//  sample_en_i  in   1        1-cycle strobe, sample_i valid
//  flush_i      in   1        sync clear of pointers/ownership/FSM (not counters)
//  irq_ack_i    in   1        CPU interrupt acknowledge pulse
//  rd_done_i    in   1        CPU finished reading window (port strobe)
//  clr_ovf_i    in   1        sync clear of ovf_o and ovf_cnt_o
//  wea_o        out  1        BRAM port-A write enable
//  addra_o      out  ADDR_W   BRAM port-A address
//  dina_o       out  DATA_W   BRAM port-A data
//  irq_o        out  1        interrupt request to CPU (level)
//  win_base_o   out  ADDR_W   base address of the window offered to CPU = {rd_bank, 0}
//  ovf_o        out  1        sticky: at least one sample dropped
//  ovf_cnt_o    out  OVF_W    dropped-sample count, saturates at all-ones
// BEHAVIOUR
//  Reset: every output 0. wr_bank=0, rd_bank=0, wr_ptr=0, full[1:0]=0, CPU FSM=C_IDLE.
//  Write path, all outputs registered (1-cycle latency):
//   - Accepting sample_en_i when full[wr_bank]==0 gives next cycle: wea_o=1, addra_o={wr_bank,wr_ptr}, dina_o=sample_i.
//   - wr_ptr increments. At wr_ptr==BANK-1: wr_ptr wraps to 0, full[wr_bank] sets, wr_bank toggles.
//   - sample_en_i with full[wr_bank]==1 is a drop: no write, ovf_o<=1, ovf_cnt_o increments (saturating).
//   - wea_o is 0 in every cycle without an accepted sample.
//  CPU FSM:
//   - C_IDLE: if full[rd_bank], go to C_IRQ; irq_o<=1; win_base_o<={rd_bank,0}.
//   - C_IRQ: hold irq_o=1 until irq_ack_i, then C_READ with irq_o<=0. rd_done_i is ignored here.
//   - C_READ: wait for rd_done_i, then full[rd_bank]<=0, rd_bank toggles, return to C_IDLE.
//     irq_ack_i is ignored here.
//   - Back-to-back: if the other bank is already full on return to C_IDLE, irq_o reasserts next cycle (one idle cycle minimum).
//  Simultaneous events:
//   - rd_done_i freeing bank X in the same cycle as sample_en_i targeting bank X: clear wins, sample accepted (no drop).
//   - A bank fill completing in the same cycle as rd_done_i on the other bank: both take effect.
//   - clr_ovf_i together with a drop: count ends at 1, ovf_o=1.
//   - flush_i has priority over all except rst_i: pointers/full/FSM to reset values, irq_o<=0, wea_o<=0.
//     An in-flight sample that cycle is discarded and not counted.
//  Invariant: the bank being written is never the bank owned by the CPU (full=1). Checked by assertion.
//  Reset asserted mid-window: asynchronous clear, no partial-bank interrupt after release.
// STRUCTURE
//  Package win_ctrl_pkg holds cpu_state_e {C_IDLE,C_IRQ,C_READ} (2-bit) and localparams BANK and PTR_W=ADDR_W-1.
//  One sub-module: sat_cnt #(OVF_W), a saturating counter with inc/clr used for ovf_cnt_o.
//  Write path and CPU FSM are separate always_ff blocks sharing only full[1:0]. ADDR_W>=2 is checked by elaboration assert.
// TESTING
//  1. 8 samples 0x0001..0x0008 -> writes addr 0..7 with matching data, 1-cycle latency.
//     irq_o=1 the cycle after full[0] sets; win_base_o=0.
//  2. Ack then rd_done_i after 8 more samples -> second irq reasserts after one idle cycle with win_base_o=8.
//     Bank 0 then writes again.
//  3. No ack, 24 samples -> 16 written, next 8 dropped, ovf_o=1, ovf_cnt_o=8, wea_o stays 0 for drops.
//  4. 300 drops with OVF_W=8 -> ovf_cnt_o=0xFF (saturated). clr_ovf_i then one drop -> ovf_cnt_o=1.
//  5. rd_done_i coincident with a sample into the blocked bank -> sample written (wea_o=1), no drop counted.
//  6. rst_i pulse mid-fill (wr_ptr=5) and flush_i with irq pending -> all outputs 0.
//     The next write goes to addr 0 and the first irq arrives only after 8 new samples.

Source files
------------

// File: rtl/win_ctrl_pkg.sv
// rtl/win_ctrl_pkg.sv - shared types and default geometry for the ping-pong BRAM window controller
package win_ctrl_pkg;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_IRQ  = 2'd1,
    C_READ = 2'd2
  } cpu_state_e;

  // Default geometry: address MSB selects the bank, the rest index within it
  localparam int ADDR_W_DEF = 4;
  localparam int PTR_W      = ADDR_W_DEF - 1;
  localparam int BANK       = 2 ** PTR_W;

endpackage

// File: rtl/sat_cnt.sv
// rtl/sat_cnt.sv - saturating up-counter with synchronous clear; clear+inc in one cycle yields 1
module sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= inc_i ? W'(1) : '0;
    end else if (inc_i && (cnt_o != {W{1'b1}})) begin
      cnt_o <= cnt_o + W'(1);
    end
  end

endmodule

// File: rtl/bram_win_ctrl.sv
// rtl/bram_win_ctrl.sv - ping-pong window controller feeding the sample BRAM port A
// Fills one bank while the CPU reads the other; interrupts once per full bank, drops when both are owned.
module bram_win_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int OVF_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              sample_en_i,
  input  logic              flush_i,
  input  logic              irq_ack_i,
  input  logic              rd_done_i,
  input  logic              clr_ovf_i,
  output logic              wea_o,
  output logic [ADDR_W-1:0] addra_o,
  output logic [DATA_W-1:0] dina_o,
  output logic              irq_o,
  output logic [ADDR_W-1:0] win_base_o,
  output logic              ovf_o,
  output logic [OVF_W-1:0]  ovf_cnt_o
);

  import win_ctrl_pkg::*;

  localparam int WP_W = ADDR_W - 1;

  generate
    if (ADDR_W < 2) begin : g_addr_chk
      $error("bram_win_ctrl: ADDR_W must be at least 2");
    end
  endgenerate

  cpu_state_e        state_q, state_d;
  logic              rd_bank_q, rd_bank_d;
  logic              irq_d;
  logic [ADDR_W-1:0] base_d;
  logic              rd_clr;

  logic              wr_bank_q;
  logic [WP_W-1:0]   wr_ptr_q;
  logic [1:0]        full_q, full_set, full_clr;
  logic              ptr_last, accept, drop;

  // A bank released this cycle is writable this cycle: the clear wins over the drop
  assign ptr_last = (wr_ptr_q == {WP_W{1'b1}});
  assign accept   = sample_en_i && !flush_i && (!full_q[wr_bank_q] || full_clr[wr_bank_q]);
  assign drop     = sample_en_i && !flush_i && !accept;

  always_comb begin
    full_set = 2'b00;
    full_clr = 2'b00;
    if (accept && ptr_last) full_set[wr_bank_q] = 1'b1;
    if (rd_clr)             full_clr[rd_bank_q] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q <= 2'b00;
    end else if (flush_i) begin
      full_q <= 2'b00;
    end else begin
      full_q <= (full_q & ~full_clr) | full_set;
    end
  end

  // Write path
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_bank_q <= 1'b0;
      wr_ptr_q  <= '0;
      wea_o     <= 1'b0;
      addra_o   <= '0;
      dina_o    <= '0;
    end else if (flush_i) begin
      wr_bank_q <= 1'b0;
      wr_ptr_q  <= '0;
      wea_o     <= 1'b0;
      addra_o   <= '0;
      dina_o    <= '0;
    end else begin
      wea_o <= accept;
      if (accept) begin
        addra_o <= {wr_bank_q, wr_ptr_q};
        dina_o  <= sample_i;
        if (ptr_last) begin
          wr_ptr_q  <= '0;
          wr_bank_q <= ~wr_bank_q;
        end else begin
          wr_ptr_q <= wr_ptr_q + WP_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_o <= 1'b0;
    end else if (drop) begin
      ovf_o <= 1'b1;
    end else if (clr_ovf_i) begin
      ovf_o <= 1'b0;
    end
  end

  sat_cnt #(.W(OVF_W)) u_ovf_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr_ovf_i),
    .inc_i (drop),
    .cnt_o (ovf_cnt_o)
  );

  // CPU ownership FSM
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= C_IDLE;
      rd_bank_q  <= 1'b0;
      irq_o      <= 1'b0;
      win_base_o <= '0;
    end else begin
      state_q    <= state_d;
      rd_bank_q  <= rd_bank_d;
      irq_o      <= irq_d;
      win_base_o <= base_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    irq_d     = irq_o;
    base_d    = win_base_o;
    rd_clr    = 1'b0;
    if (flush_i) begin
      state_d   = C_IDLE;
      rd_bank_d = 1'b0;
      irq_d     = 1'b0;
      base_d    = '0;
    end else begin
      case (state_q)
        C_IDLE: begin
          if (full_q[rd_bank_q]) begin
            state_d = C_IRQ;
            irq_d   = 1'b1;
            base_d  = {rd_bank_q, {WP_W{1'b0}}};
          end
        end
        C_IRQ: begin
          if (irq_ack_i) begin
            state_d = C_READ;
            irq_d   = 1'b0;
          end
        end
        C_READ: begin
          if (rd_done_i) begin
            rd_clr    = 1'b1;
            rd_bank_d = ~rd_bank_q;
            state_d   = C_IDLE;
          end
        end
        default: begin
          state_d = C_IDLE;
          irq_d   = 1'b0;
        end
      endcase
    end
  end

  // With exactly one bank owned, it must never be the one being filled
  a_wr_not_owned: assert property (@(posedge clk_i) disable iff (rst_i)
    (^full_q) |-> !full_q[wr_bank_q]);

endmodule
